// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised full-duplex UART transceiver.
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// TX takes words over a valid/ready handshake. RX samples a synchronised line at mid-bit.
//
// Both FSMs share one state encoding (WAIT_HIGH is used by RX only):
//   state      | meaning
//   S_IDLE     | line idle; TX ready for a word / RX waiting for a falling edge
//   S_START    | start bit (RX: half-bit qualification of the start bit)
//   S_DATA     | data bits, LSB first
//   S_PARITY   | parity bit (only reached when PARITY_EN=1)
//   S_STOP     | stop bit(s)
//   S_WAIT_HIGH| RX only: a stop bit was low; hold off until the line returns high
module uart_xcvr #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err
);

  localparam int FRAME_BITS = 1 + DATA_WIDTH + PARITY_EN + STOP_BITS;
  localparam int CBW = $clog2(CLKS_PER_BIT);
  localparam int FBW = $clog2(FRAME_BITS);

  localparam logic [CBW-1:0] BIT_LAST  = CBW'(CLKS_PER_BIT - 1);
  localparam logic [CBW-1:0] HALF_LAST = CBW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FBW-1:0] DATA_LAST = FBW'(DATA_WIDTH - 1);
  localparam logic [FBW-1:0] STOP_LAST = FBW'(STOP_BITS - 1);
  localparam logic PEN = (PARITY_EN != 0);
  localparam logic ODD = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic [2:0]            tx_state;
  logic [CBW-1:0]        tx_tmr;
  logic [FBW-1:0]        tx_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic                  tx_par;

  logic                  rx_s1, rx_s2;
  logic [2:0]            rx_state;
  logic [CBW-1:0]        rx_tmr;
  logic [FBW-1:0]        rx_cnt;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  rx_par;
  logic                  stop_bad;

  assign tx_ready = (tx_state == S_IDLE);

  // TX FSM: bit timer is a down-counter; each terminal count moves to the next bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_tmr   <= '0;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else if (tx_state == S_IDLE) begin
      if (tx_valid) begin
        tx_sh    <= tx_data;
        tx_par   <= (^tx_data) ^ ODD;
        tx       <= 1'b0;
        tx_tmr   <= BIT_LAST;
        tx_state <= S_START;
      end
    end else if (tx_tmr != '0) begin
      tx_tmr <= tx_tmr - 1'b1;
    end else begin
      tx_tmr <= BIT_LAST;
      case (tx_state)
        S_START: begin
          tx       <= tx_sh[0];
          tx_sh    <= tx_sh >> 1;
          tx_cnt   <= '0;
          tx_state <= S_DATA;
        end
        S_DATA: begin
          if (tx_cnt == DATA_LAST) begin
            tx_cnt <= '0;
            if (PEN) begin
              tx       <= tx_par;
              tx_state <= S_PARITY;
            end else begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end
          end else begin
            tx     <= tx_sh[0];
            tx_sh  <= tx_sh >> 1;
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          tx       <= 1'b1;
          tx_state <= S_STOP;
        end
        S_STOP: begin
          if (tx_cnt == STOP_LAST) tx_state <= S_IDLE;
          else                     tx_cnt   <= tx_cnt + 1'b1;
        end
        default: begin
          tx       <= 1'b1;
          tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // RX FSM: half-bit start qualification, then one mid-bit sample per bit period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state      <= S_IDLE;
      rx_tmr        <= '0;
      rx_cnt        <= '0;
      rx_sh         <= '0;
      rx_par        <= 1'b0;
      stop_bad      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_state == S_IDLE) begin
        if (!rx_s2) begin
          rx_tmr   <= HALF_LAST;
          stop_bad <= 1'b0;
          rx_state <= S_START;
        end
      end else if (rx_state == S_WAIT_HIGH) begin
        if (rx_s2) rx_state <= S_IDLE;
      end else if (rx_tmr != '0) begin
        rx_tmr <= rx_tmr - 1'b1;
      end else begin
        rx_tmr <= BIT_LAST;
        case (rx_state)
          S_START: begin
            rx_cnt   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            rx_sh <= {rx_s2, rx_sh[DATA_WIDTH-1:1]};
            if (rx_cnt == DATA_LAST) begin
              rx_cnt   <= '0;
              rx_state <= PEN ? S_PARITY : S_STOP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            rx_par   <= rx_s2;
            rx_state <= S_STOP;
          end
          S_STOP: begin
            if (rx_cnt == STOP_LAST) begin
              rx_data       <= rx_sh;
              rx_valid      <= 1'b1;
              rx_parity_err <= PEN & ((^rx_sh) ^ rx_par ^ ODD);
              rx_frame_err  <= stop_bad | ~rx_s2;
              rx_state      <= (stop_bad | ~rx_s2) ? S_WAIT_HIGH : S_IDLE;
            end else begin
              stop_bad <= stop_bad | ~rx_s2;
              rx_cnt   <= rx_cnt + 1'b1;
            end
          end
          default: rx_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: directed bench for uart_xcvr.
// u0: 8N1 with optional tx->rx loopback; u1: even parity; u2: odd parity.
module tb_uart_xcvr;

  logic       clk;
  logic       reset;
  logic       loop;
  logic [2:0] tx_valid_v;
  logic [7:0] tx_data_v [3];
  logic [2:0] rx_drv;
  logic [2:0] tx_w, tx_ready_w, rx_valid_w, perr_w, ferr_w;
  logic [7:0] rx_data_w [3];
  logic       rx_in0;

  int         n_checks = 0;
  int         n_errors = 0;
  int         rx_cnt [3] = '{0, 0, 0};
  logic [9:0] rx_log [16];

  logic [15:0] bits;
  int          low;
  int          base;

  assign rx_in0 = loop ? tx_w[0] : rx_drv[0];

  uart_xcvr u0 (
    .clk(clk), .reset(reset), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
    .tx_ready(tx_ready_w[0]), .tx(tx_w[0]), .rx(rx_in0), .rx_data(rx_data_w[0]),
    .rx_valid(rx_valid_w[0]), .rx_parity_err(perr_w[0]), .rx_frame_err(ferr_w[0])
  );

  uart_xcvr #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
    .tx_ready(tx_ready_w[1]), .tx(tx_w[1]), .rx(rx_drv[1]), .rx_data(rx_data_w[1]),
    .rx_valid(rx_valid_w[1]), .rx_parity_err(perr_w[1]), .rx_frame_err(ferr_w[1])
  );

  uart_xcvr #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .tx_data(tx_data_v[2]), .tx_valid(tx_valid_v[2]),
    .tx_ready(tx_ready_w[2]), .tx(tx_w[2]), .rx(rx_drv[2]), .rx_data(rx_data_w[2]),
    .rx_valid(rx_valid_w[2]), .rx_parity_err(perr_w[2]), .rx_frame_err(ferr_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rx_valid pulses per instance and log u0 receptions.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rx_valid_w[k]) begin
        if (k == 0 && rx_cnt[0] < 16) rx_log[rx_cnt[0]] = {ferr_w[0], perr_w[0], rx_data_w[0]};
        rx_cnt[k] = rx_cnt[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Handshake one word into instance k, then sample tx mid-bit until tx_ready returns.
  task automatic send_tx(input int k, input logic [7:0] d, output logic [15:0] b, output int lo);
    @(negedge clk);
    tx_data_v[k]  = d;
    tx_valid_v[k] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid_v[k] = 1'b0;
    tx_data_v[k]  = ~d;
    lo = 0;
    b  = '0;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (tx_ready_w[k]) break;
      lo++;
      if (j % 16 == 8 && j < 256) b[j/16] = tx_w[k];
    end
  endtask

  // Drive n serial bits (LSB first) onto rx of instance k; call at a negedge.
  task automatic drive_rx(input int k, input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv[k] = b[i];
      repeat (16) @(negedge clk);
    end
  endtask

  logic [7:0] lb_words [3];

  initial begin
    lb_words[0] = 8'h00; lb_words[1] = 8'hFF; lb_words[2] = 8'h3C;
    reset = 1'b0;
    loop  = 1'b0;
    tx_valid_v = '0;
    for (int k = 0; k < 3; k++) tx_data_v[k] = '0;
    rx_drv = 3'b111;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_w[0]), 1);
    check("rst_tx_ready", 32'(tx_ready_w[0]), 1);
    check("rst_rx_data", 32'(rx_data_w[0]), 0);
    check("rst_rx_valid", 32'(rx_valid_w[0]), 0);
    check("rst_perr", 32'(perr_w[1]), 0);
    check("rst_ferr", 32'(ferr_w[0]), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1: TX 0xA5, 8N1
    send_tx(0, 8'hA5, bits, low);
    check("tx_a5_bits", 32'(bits[9:0]), 32'h34A);
    check("tx_a5_busy", low, 160);

    // 2: loopback, tx_valid held high
    loop = 1'b1;
    base = rx_cnt[0];
    @(negedge clk);
    tx_data_v[0]  = lb_words[0];
    tx_valid_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("lb_accept", 32'(tx_ready_w[0]), 0);
      if (i < 2) tx_data_v[0] = lb_words[i+1];
      else       tx_valid_v[0] = 1'b0;
      low = 0;
      for (int j = 0; j < 400; j++) begin
        @(negedge clk);
        if (tx_ready_w[0]) break;
        low++;
      end
      check("lb_busy", low, 160);
    end
    repeat (40) @(negedge clk);
    check("lb_count", rx_cnt[0] - base, 3);
    for (int i = 0; i < 3; i++)
      check("lb_word", 32'(rx_log[(base + i) % 16]), 32'({2'b00, lb_words[i]}));
    loop = 1'b0;

    // 3: parity generation and checking
    send_tx(1, 8'h07, bits, low);
    check("par_even_frame", 32'(bits[10:0]), 32'h60E);
    check("par_even_bit", 32'(bits[9]), 1);
    check("par_even_busy", low, 176);
    send_tx(2, 8'h07, bits, low);
    check("par_odd_frame", 32'(bits[10:0]), 32'h40E);
    check("par_odd_bit", 32'(bits[9]), 0);
    base = rx_cnt[1];
    drive_rx(1, 16'h060E, 11);
    repeat (4) @(negedge clk);
    check("par_rx_good_cnt", rx_cnt[1] - base, 1);
    check("par_rx_good_data", 32'(rx_data_w[1]), 32'h07);
    check("par_rx_good_perr", 32'(perr_w[1]), 0);
    drive_rx(1, 16'h040E, 11);
    repeat (4) @(negedge clk);
    check("par_rx_bad_cnt", rx_cnt[1] - base, 2);
    check("par_rx_bad_perr", 32'(perr_w[1]), 1);
    check("par_rx_bad_ferr", 32'(ferr_w[1]), 0);

    // 4: start-bit glitch, then a good 0x5A frame
    base = rx_cnt[0];
    rx_drv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_valid", rx_cnt[0] - base, 0);
    drive_rx(0, 16'h02B4, 10);
    repeat (4) @(negedge clk);
    check("glitch_next_cnt", rx_cnt[0] - base, 1);
    check("glitch_next_data", 32'(rx_data_w[0]), 32'h5A);
    check("glitch_next_ferr", 32'(ferr_w[0]), 0);

    // 5: low stop bit, then line held low (break)
    base = rx_cnt[0];
    drive_rx(0, 16'h0066, 10);
    repeat (100) @(negedge clk);
    check("brk_cnt", rx_cnt[0] - base, 1);
    check("brk_ferr", 32'(ferr_w[0]), 1);
    check("brk_data", 32'(rx_data_w[0]), 32'h33);
    rx_drv[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("brk_hold_cnt", rx_cnt[0] - base, 1);
    drive_rx(0, 16'h0386, 10);
    repeat (4) @(negedge clk);
    check("brk_next_cnt", rx_cnt[0] - base, 2);
    check("brk_next_data", 32'(rx_data_w[0]), 32'hC3);
    check("brk_next_ferr", 32'(ferr_w[0]), 0);

    // 6: reset in the middle of a TX and an RX frame
    base = rx_cnt[0];
    @(negedge clk);
    tx_data_v[0]  = 8'h81;
    tx_valid_v[0] = 1'b1;
    rx_drv[0]     = 1'b0;
    @(posedge clk);
    #1;
    tx_valid_v[0] = 1'b0;
    repeat (50) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx_w[0]), 1);
    check("mid_rst_ready", 32'(tx_ready_w[0]), 1);
    check("mid_rst_rx_data", 32'(rx_data_w[0]), 0);
    rx_drv[0] = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    check("mid_rst_no_valid", rx_cnt[0] - base, 0);
    loop = 1'b1;
    send_tx(0, 8'h96, bits, low);
    check("post_rst_bits", 32'(bits[9:0]), 32'h32C);
    check("post_rst_busy", low, 160);
    repeat (20) @(negedge clk);
    check("post_rst_rx_cnt", rx_cnt[0] - base, 1);
    check("post_rst_rx_data", 32'(rx_data_w[0]), 32'h96);
    loop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
